// File: rtl/ser_pkg.sv
// Shared types and constants for the ser_par_n serialiser family.
package ser_pkg;

    localparam int DEF_OUT_W = 16;
    localparam int DEF_RATIO = 4;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Ceiling log2, floored at 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ser_word_buf.sv
// ser_word_buf: one-entry valid/stop holding register; it stops upstream exactly while full.
module ser_word_buf
    import ser_pkg::*;
#(
    parameter int IN_W = DEF_OUT_W * DEF_RATIO
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic            valid_in,
    output logic            stop_out,
    input  logic [IN_W-1:0] data_in,
    output logic            valid_out,
    input  logic            stop_in,
    output logic [IN_W-1:0] data_out
);

    logic full;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            full     <= 1'b0;
            data_out <= '0;
        end else if (valid_in && !full) begin
            full     <= 1'b1;
            data_out <= data_in;
        end else if (full && !stop_in) begin
            full <= 1'b0;
        end
    end

    assign stop_out  = full;
    assign valid_out = full;

endmodule

// File: rtl/ser_par_n.sv
// ser_par_n: N:1 word serialiser with valid/stop handshakes on both sides.
// Define SER_INPUT_BUF_EN to add a one-word input buffer for bubble-free streaming.
module ser_par_n
    import ser_pkg::*;
#(
    parameter int  OUT_W     = DEF_OUT_W,
    parameter int  RATIO     = DEF_RATIO,
    parameter bit  MSB_FIRST = 1'b0,
    localparam int IN_W      = OUT_W * RATIO,
    localparam int CNT_W     = clog2(RATIO)
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             valid_in,
    output logic             stop_out,
    input  logic [IN_W-1:0]  data_in,
    output logic             valid_out,
    input  logic             stop_in,
    output logic [OUT_W-1:0] data_out,
    output logic             last_out
);

    state_t           state;
    state_t           state_next;
    logic [IN_W-1:0]  shreg;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             xfer;
    logic             last_xfer;
    logic             load;
    logic [IN_W-1:0]  load_word;

    // The next slice always sits at the same end of the shifter, so no wide mux is needed.
    function automatic logic [OUT_W-1:0] head(input logic [IN_W-1:0] w);
        return MSB_FIRST ? w[IN_W-1 -: OUT_W] : w[OUT_W-1:0];
    endfunction

    function automatic logic [IN_W-1:0] tail(input logic [IN_W-1:0] w);
        return MSB_FIRST ? (w << OUT_W) : (w >> OUT_W);
    endfunction

    assign accept    = valid_in & ~stop_out;
    assign xfer      = valid_out & ~stop_in;
    assign last_xfer = xfer & last_out;

`ifdef SER_INPUT_BUF_EN
    logic            direct;
    logic            buf_valid;
    logic [IN_W-1:0] buf_data;

    // A word bypasses the buffer whenever the shifter is free by the end of this edge.
    assign direct = accept & ((state == S_EMPTY) | last_xfer);

    ser_word_buf #(.IN_W(IN_W)) u_buf (
        .clk       (clk),
        .res_n     (res_n),
        .valid_in  (accept & ~direct),
        .stop_out  (stop_out),
        .data_in   (data_in),
        .valid_out (buf_valid),
        .stop_in   (~last_xfer),
        .data_out  (buf_data)
    );

    assign load      = direct | (buf_valid & last_xfer);
    assign load_word = buf_valid ? buf_data : data_in;
`else
    assign load      = accept;
    assign load_word = data_in;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) stop_out <= 1'b0;
        else        stop_out <= (state_next == S_SHIFT);
    end
`endif

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= S_EMPTY;
        else        state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: if (load) state_next = S_SHIFT;
            S_SHIFT: if (last_xfer && !load) state_next = S_EMPTY;
            default: state_next = S_EMPTY;
        endcase
    end

    // NOTE: the shifter is reset with the control path so a word cut short by reset can never resurface.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            shreg     <= '0;
            data_out  <= '0;
            cnt       <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else if (load) begin
            shreg     <= tail(load_word);
            data_out  <= head(load_word);
            cnt       <= '0;
            valid_out <= 1'b1;
            last_out  <= 1'b0;
        end else if (last_xfer) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else if (xfer) begin
            shreg     <= tail(shreg);
            data_out  <= head(shreg);
            cnt       <= cnt + 1'b1;
            last_out  <= (cnt == CNT_W'(RATIO - 2));
        end
    end

endmodule

// File: tb/tb_ser_par_n.sv
// Bench for ser_par_n: three instances (16x4 LSB-first, 16x4 MSB-first, 8x3) against a slice-queue model.
module tb_ser_par_n;

`ifdef SER_INPUT_BUF_EN
    localparam int EXP_SPAN      = 7;
    localparam int EXP_GAP       = 0;
    localparam bit EXP_STOP_BUSY = 1'b0;
`else
    localparam int EXP_SPAN      = 8;
    localparam int EXP_GAP       = 1;
    localparam bit EXP_STOP_BUSY = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        res_n = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_stop = 1'b0;
    logic [63:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_stop = 1'b0;
    logic [23:0] b_data = '0;

    logic        a0_stop, a0_vout, a0_last;
    logic [15:0] a0_dout;
    logic        a1_stop, a1_vout, a1_last;
    logic [15:0] a1_dout;
    logic        b_stop_o, b_vout, b_last;
    logic [7:0]  b_dout;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int gap_cnt  = 0;
    bit chk_en   = 1'b0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ser_par_n #(.OUT_W(16), .RATIO(4), .MSB_FIRST(1'b0)) u0 (
        .clk(clk), .res_n(res_n), .valid_in(a_valid), .stop_out(a0_stop), .data_in(a_data),
        .valid_out(a0_vout), .stop_in(a_stop), .data_out(a0_dout), .last_out(a0_last));

    ser_par_n #(.OUT_W(16), .RATIO(4), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .res_n(res_n), .valid_in(a_valid), .stop_out(a1_stop), .data_in(a_data),
        .valid_out(a1_vout), .stop_in(a_stop), .data_out(a1_dout), .last_out(a1_last));

    ser_par_n #(.OUT_W(8), .RATIO(3), .MSB_FIRST(1'b0)) u2 (
        .clk(clk), .res_n(res_n), .valid_in(b_valid), .stop_out(b_stop_o), .data_in(b_data),
        .valid_out(b_vout), .stop_in(b_stop), .data_out(b_dout), .last_out(b_last));

    // Model: each instance holds the remaining slices of its current word, plus an optional waiting word.
    logic [15:0] m_sl [3][4];
    int          m_cnt [3];
    int          m_pos [3];
    logic        m_stop [3];
`ifdef SER_INPUT_BUF_EN
    logic        m_bfull [3];
    logic [63:0] m_bw [3];
`endif

    function automatic int cfg_ow(input int id);
        return (id == 2) ? 8 : 16;
    endfunction

    function automatic int cfg_ratio(input int id);
        return (id == 2) ? 3 : 4;
    endfunction

    function automatic logic [15:0] slice_of(input logic [63:0] w, input int id, input int k);
        int          s;
        logic [63:0] m;
        s = (id == 1) ? (cfg_ratio(id) - 1 - k) : k;
        m = (64'd1 << cfg_ow(id)) - 64'd1;
        return 16'((w >> (cfg_ow(id) * s)) & m);
    endfunction

    task automatic m_reset(input int id);
        m_cnt[id]  = 0;
        m_pos[id]  = 0;
        m_stop[id] = 1'b0;
`ifdef SER_INPUT_BUF_EN
        m_bfull[id] = 1'b0;
`endif
    endtask

    task automatic m_load(input int id, input logic [63:0] w);
        for (int k = 0; k < cfg_ratio(id); k++) m_sl[id][k] = slice_of(w, id, k);
        m_pos[id] = 0;
        m_cnt[id] = cfg_ratio(id);
    endtask

    task automatic m_step(input int id, input logic vin, input logic [63:0] din, input logic sin);
        logic acc;
        acc = vin && !m_stop[id];
        if (m_cnt[id] > 0 && !sin) begin
            m_cnt[id]--;
            m_pos[id]++;
        end
`ifdef SER_INPUT_BUF_EN
        if (m_cnt[id] == 0 && m_bfull[id]) begin
            m_load(id, m_bw[id]);
            m_bfull[id] = 1'b0;
        end
        if (acc) begin
            if (m_cnt[id] == 0) m_load(id, din);
            else begin
                m_bw[id]    = din;
                m_bfull[id] = 1'b1;
            end
        end
        m_stop[id] = m_bfull[id];
`else
        if (acc) m_load(id, din);
        m_stop[id] = (m_cnt[id] > 0);
`endif
    endtask

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < 3; i++) m_reset(i);
        end else begin
            m_step(0, a_valid, a_data, a_stop);
            m_step(1, a_valid, a_data, a_stop);
            m_step(2, b_valid, {40'd0, b_data}, b_stop);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int id, input logic v, input logic l, input logic s, input logic [15:0] d);
        check($sformatf("u%0d valid_out", id), {63'd0, v}, {63'd0, m_cnt[id] > 0});
        check($sformatf("u%0d last_out", id), {63'd0, l}, {63'd0, m_cnt[id] == 1});
        check($sformatf("u%0d stop_out", id), {63'd0, s}, {63'd0, m_stop[id]});
        if (m_cnt[id] > 0)
            check($sformatf("u%0d data_out", id), {48'd0, d}, {48'd0, m_sl[id][m_pos[id]]});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, a0_vout, a0_last, a0_stop, a0_dout);
            cmp(1, a1_vout, a1_last, a1_stop, a1_dout);
            cmp(2, b_vout, b_last, b_stop_o, {8'd0, b_dout});
        end
    end

    always @(negedge clk) if (mon_en && !a0_vout) gap_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word to the 16-bit pair and hold it until the model says it was taken.
    task automatic send_a(input logic [63:0] w);
        logic acc;
        a_valid = 1'b1;
        a_data  = w;
        for (int t = 0; t < 50; t++) begin
            acc = !m_stop[0];
            tick();
            if (acc) begin
                a_valid = 1'b0;
                return;
            end
        end
        n_checks++;
        n_err++;
        $display("FAIL send_a timeout: word %0h not accepted within 50 cycles", w);
        a_valid = 1'b0;
    endtask

    initial begin
        int c0, g0, span;

        #1 res_n = 1'b0;
        chk_en = 1'b1;
        #2;
        check("reset valid_out", {63'd0, a0_vout}, 64'd0);
        check("reset last_out", {63'd0, a0_last}, 64'd0);
        check("reset stop_out", {63'd0, a0_stop}, 64'd0);
        check("reset data_out", {48'd0, a0_dout}, 64'd0);
        check("reset u2 valid_out", {63'd0, b_vout}, 64'd0);
        repeat (2) @(posedge clk);
        #3 res_n = 1'b1;
        tick();

        // 8x3 instance: valid held, data changed while the word is being serialised
        b_valid = 1'b1;
        b_data  = 24'h332211;
        tick();
        b_data = 24'hFFFFFF;
        check("u2 slice0", {56'd0, b_dout}, 64'h11);
        tick();
        check("u2 slice1", {56'd0, b_dout}, 64'h22);
        tick();
        check("u2 slice2", {56'd0, b_dout}, 64'h33);
        check("u2 slice2 last", {63'd0, b_last}, 64'd1);
        b_valid = 1'b0;
        repeat (8) tick();

        // Plain word, both slice orders
        send_a(64'h4444_3333_2222_1111);
        check("lsb s0", {48'd0, a0_dout}, 64'h1111);
        check("msb s0", {48'd0, a1_dout}, 64'h4444);
        check("s0 last", {63'd0, a0_last}, 64'd0);
        check("stop while busy", {63'd0, a0_stop}, {63'd0, EXP_STOP_BUSY});
        tick();
        check("lsb s1", {48'd0, a0_dout}, 64'h2222);
        check("msb s1", {48'd0, a1_dout}, 64'h3333);
        tick();
        check("lsb s2", {48'd0, a0_dout}, 64'h3333);
        check("msb s2", {48'd0, a1_dout}, 64'h2222);
        tick();
        check("lsb s3", {48'd0, a0_dout}, 64'h4444);
        check("msb s3", {48'd0, a1_dout}, 64'h1111);
        check("lsb s3 last", {63'd0, a0_last}, 64'd1);
        check("msb s3 last", {63'd0, a1_last}, 64'd1);
        tick();
        check("idle after word", {63'd0, a0_vout}, 64'd0);
        repeat (2) tick();

        // Downstream stall on the second slice
        send_a(64'h4444_3333_2222_1111);
        tick();
        a_stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall hold", {48'd0, a0_dout}, 64'h2222);
        end
        a_stop = 1'b0;
        tick();
        check("after stall", {48'd0, a0_dout}, 64'h3333);
        repeat (4) tick();

        // Back-to-back words
        send_a(64'hAAA4_AAA3_AAA2_AAA1);
        c0 = cyc;
        g0 = gap_cnt;
        mon_en = 1'b1;
        send_a(64'hBBB4_BBB3_BBB2_BBB1);
        for (int t = 0; t < 20; t++) begin
            if (a0_vout && a0_last && a0_dout == 16'hBBB4) break;
            tick();
        end
        mon_en = 1'b0;
        span = cyc - c0;
        check("b2b span", 64'(span), 64'(EXP_SPAN));
        check("b2b gap", 64'(gap_cnt - g0), 64'(EXP_GAP));
        repeat (4) tick();

        // Reset in the middle of a word
        send_a(64'h0F0F_0E0E_0D0D_0C0C);
        repeat (2) tick();
        #2 res_n = 1'b0;
        #1;
        check("midrst valid_out", {63'd0, a0_vout}, 64'd0);
        check("midrst last_out", {63'd0, a0_last}, 64'd0);
        check("midrst stop_out", {63'd0, a0_stop}, 64'd0);
        check("midrst data_out", {48'd0, a0_dout}, 64'd0);
        @(posedge clk);
        #3 res_n = 1'b1;
        tick();
        check("post-reset idle", {63'd0, a0_vout}, 64'd0);
        send_a(64'h4D4C_3B3A_2928_1716);
        check("post-reset lsb s0", {48'd0, a0_dout}, 64'h1716);
        check("post-reset msb s0", {48'd0, a1_dout}, 64'h4D4C);
        repeat (6) tick();

        // Randomised traffic: long stall window, then saturated streaming
        for (int i = 0; i < 420; i++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_data  = {$urandom, $urandom};
            a_stop  = ($urandom_range(0, 3) == 0);
            if (i >= 150 && i < 180) a_stop = 1'b1;
            if (i >= 320) begin
                a_valid = 1'b1;
                a_stop  = 1'b0;
            end
            b_valid = (i < 320) ? ($urandom_range(0, 4) != 0) : 1'b1;
            b_data  = 24'($urandom);
            b_stop  = (i < 320) ? ($urandom_range(0, 4) == 0) : 1'b0;
            tick();
        end
        a_valid = 1'b0;
        a_stop  = 1'b0;
        b_valid = 1'b0;
        b_stop  = 1'b0;
        repeat (12) tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
